version_streamer: RTL and testbench
===================================

VERSION_STREAMER -- requirements
Module: version_streamer

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, which is the first byte of every frame.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 0, giving the auto-send period in clk cycles; 0 disables auto-send.
REQ-003 SHALL have port clk, input, 1 bit, the single clock for the block.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 1 bit, a single-cycle frame-send request.
REQ-006 SHALL have port out_data, output, 8 bits, the stream byte.
REQ-007 SHALL have port out_valid, output, 1 bit, which marks out_data as valid.
REQ-008 SHALL have port out_ready, input, 1 bit, the downstream accept signal (e.g. UART tx).
REQ-009 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse marking frame completion.

Function
REQ-011 SHALL send this frame, byte order fixed: HEADER, MAJOR, MINOR, PATCH, BUILD, YEAR[15:8], YEAR[7:0], MONTH, DAY, HOUR, MINUTE, SECOND, then CHK (only if enabled per REQ-025).
REQ-012 SHALL take all field values from the version_pkg constants.
REQ-013 SHALL compute CHK as the XOR of the 11 payload bytes, excluding HEADER.
REQ-014 SHALL define trigger = req OR tick, where tick is a one-cycle pulse every REPEAT_CYCLES cycles when REPEAT_CYCLES > 0.
REQ-015 SHALL implement a state machine with states IDLE and SEND:
- IDLE -> SEND on trigger.
- SEND -> IDLE on the handshake of the last byte, unless pending.
REQ-016 SHALL have a latency of one cycle: trigger sampled at edge N gives out_valid=1 with out_data=HEADER after edge N.
REQ-017 SHALL define a handshake as out_valid AND out_ready at a rising edge.
- Byte index advances only on a handshake.
- out_data is held stable while out_valid=1 and out_ready=0.
REQ-018 SHALL keep out_valid high continuously in SEND; no idle gaps between bytes.
REQ-019 SHALL handle a trigger in SEND by setting a one-deep pending flag; further triggers while pending is set are dropped.
REQ-020 SHALL, on the last-byte handshake with pending=1:
- reset the index to 0 and clear pending;
- keep out_valid=1 and present HEADER next cycle (back-to-back frames);
- still pulse done.
REQ-021 SHALL assert done for exactly one cycle, the cycle after the last-byte handshake.
REQ-022 SHALL drive busy=1 exactly while in SEND.
REQ-023 SHALL size the tick counter as clog2(REPEAT_CYCLES) bits; it is free-running, wraps at REPEAT_CYCLES-1, and is independent of state.

Reset
REQ-024 SHALL, on rst_n low, asynchronously go to IDLE and set index=0, pending=0, tick counter=0, out_valid=0, out_data=8'h00, busy=0, done=0; reset mid-frame abandons the frame with no done pulse.

Configuration
REQ-025 SHALL use macro VERSION_STREAMER_CHK_EN:
- Defined: the frame is 13 bytes including CHK.
- Undefined: the frame is 12 bytes, with no CHK logic or byte.

Structure
REQ-026 SHALL read field constants from version_pkg.
REQ-027 SHALL put frame-length constants (C_VSTREAM_LEN_CHK=13, C_VSTREAM_LEN_NOCHK=12) and a byte-index typedef in a shared package version_stream_pkg.
REQ-028 SHALL implement the periodic tick generator as sub-module version_tick_gen.

Verification
REQ-029 SHALL cover single req with out_ready=1 and CHK enabled -> 13 consecutive bytes A5,MAJ,MIN,PAT,BLD,YH,YL,MO,DA,HR,MI,SE,CHK, done at cycle 14; for build 0x37 dated 2025-11-05 19:45:54 with 0.0.0 the expected CHK is 0x2E.
REQ-030 SHALL cover out_ready toggling 1,0,0,1 -> out_data held during stalls, all 13 bytes delivered in order with no duplicates.
REQ-031 SHALL cover req at bytes 3 and 5 of the same frame -> exactly one extra back-to-back frame, out_valid never drops, two done pulses.
REQ-032 SHALL cover rst_n low at byte 6 -> all outputs 0 immediately, no done; next req -> a full frame starting at HEADER.
REQ-033 SHALL cover REPEAT_CYCLES=50 with req=0 and out_ready=1 -> frames start every 50 cycles, busy for 13 cycles each.
REQ-034 SHALL cover the build without VERSION_STREAMER_CHK_EN -> 12-byte frame ending in SECOND, done at cycle 13.

Source files
------------

// File: rtl/version_pkg.sv
// Build identification constants streamed by version_streamer.
// Date/time fields are BCD: 2025-11-05 19:45:54 reads directly as hex.
package version_pkg;
    localparam logic [7:0]  C_VER_MAJOR  = 8'h00;
    localparam logic [7:0]  C_VER_MINOR  = 8'h00;
    localparam logic [7:0]  C_VER_PATCH  = 8'h00;
    localparam logic [7:0]  C_VER_BUILD  = 8'h37;
    localparam logic [15:0] C_VER_YEAR   = 16'h2025;
    localparam logic [7:0]  C_VER_MONTH  = 8'h11;
    localparam logic [7:0]  C_VER_DAY    = 8'h05;
    localparam logic [7:0]  C_VER_HOUR   = 8'h19;
    localparam logic [7:0]  C_VER_MINUTE = 8'h45;
    localparam logic [7:0]  C_VER_SECOND = 8'h54;
endpackage

// File: rtl/version_stream_pkg.sv
// Frame-length constants, byte-index type and FSM states for version_streamer.
package version_stream_pkg;
    localparam int C_VSTREAM_LEN_CHK   = 13;
    localparam int C_VSTREAM_LEN_NOCHK = 12;

    // Wide enough to index the longest frame (0..12).
    typedef logic [3:0] vstream_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } vstream_state_t;
endpackage

// File: rtl/version_tick_gen.sv
// Free-running periodic tick: one-cycle pulse every REPEAT_CYCLES cycles.
// REPEAT_CYCLES = 0 keeps the tick permanently low.
module version_tick_gen #(
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);
    // Periods of 0 or 1 still need a 1-bit counter; it simply never leaves 0.
    localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // Wrap at REPEAT_CYCLES-1, independent of any frame activity.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick_o = (REPEAT_CYCLES != 0) && (cnt_q == LAST);
endmodule

// File: rtl/version_streamer.sv
// Streams a fixed build-version frame over a valid/ready byte interface.
// Optional trailing XOR checksum byte enabled by VERSION_STREAMER_CHK_EN.
module version_streamer
    import version_pkg::*;
    import version_stream_pkg::*;
#(
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter int         REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
`ifdef VERSION_STREAMER_CHK_EN
    localparam int LEN = C_VSTREAM_LEN_CHK;
    // XOR of every payload byte; HEADER is excluded.
    localparam logic [7:0] C_CHK = C_VER_MAJOR ^ C_VER_MINOR ^ C_VER_PATCH ^ C_VER_BUILD
                                 ^ C_VER_YEAR[15:8] ^ C_VER_YEAR[7:0] ^ C_VER_MONTH
                                 ^ C_VER_DAY ^ C_VER_HOUR ^ C_VER_MINUTE ^ C_VER_SECOND;
`else
    localparam int LEN = C_VSTREAM_LEN_NOCHK;
`endif
    localparam vstream_idx_t LAST_IDX = vstream_idx_t'(LEN - 1);

    vstream_state_t state_q, state_d;
    vstream_idx_t   idx_q, idx_d;
    logic           pend_q, pend_d;
    logic           done_q, done_d;
    logic           tick, trig, hs, last;
    logic [7:0]     byte_sel;

    version_tick_gen #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_tick (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tick_o (tick)
    );

    assign trig = req | tick;
    assign hs   = (state_q == ST_SEND) && out_ready;
    assign last = (idx_q == LAST_IDX);

    // Frame byte selected by the current index.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            4'd0:    byte_sel = HEADER;
            4'd1:    byte_sel = C_VER_MAJOR;
            4'd2:    byte_sel = C_VER_MINOR;
            4'd3:    byte_sel = C_VER_PATCH;
            4'd4:    byte_sel = C_VER_BUILD;
            4'd5:    byte_sel = C_VER_YEAR[15:8];
            4'd6:    byte_sel = C_VER_YEAR[7:0];
            4'd7:    byte_sel = C_VER_MONTH;
            4'd8:    byte_sel = C_VER_DAY;
            4'd9:    byte_sel = C_VER_HOUR;
            4'd10:   byte_sel = C_VER_MINUTE;
            4'd11:   byte_sel = C_VER_SECOND;
`ifdef VERSION_STREAMER_CHK_EN
            4'd12:   byte_sel = C_CHK;
`endif
            default: byte_sel = 8'h00;
        endcase
    end

    // Next-state: index advances on handshake only; a trigger during a frame
    // is remembered once and restarts the frame back-to-back at its end.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (hs && last) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    pend_d = 1'b0;
                    // A trigger landing on the final handshake also restarts.
                    if (!(pend_q || trig)) state_d = ST_IDLE;
                end else begin
                    if (hs)   idx_d  = idx_q + 4'd1;
                    if (trig) pend_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any frame without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign out_data  = (state_q == ST_SEND) ? byte_sel : 8'h00;
    assign done      = done_q;
endmodule

// File: tb/tb_version_streamer.sv
// Directed bench for version_streamer (checksum byte when VERSION_STREAMER_CHK_EN).
module tb_version_streamer;
`ifdef VERSION_STREAMER_CHK_EN
    localparam int LEN = 13;
`else
    localparam int LEN = 12;
`endif
    // Hand-written frame for build 0x37, 0.0.0, BCD 2025-11-05 19:45:54; CHK = 0x2E.
    logic [7:0] exp_b [0:12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h37, 8'h20, 8'h25,
                                 8'h11, 8'h05, 8'h19, 8'h45, 8'h54, 8'h2E};

    logic       clk = 1'b0;
    logic       rst_n, req, out_ready;
    logic [7:0] out_data;
    logic       out_valid, busy, done;
    logic       rst2_n, req2, out_ready2;
    logic [7:0] out_data2;
    logic       out_valid2, busy2, done2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    version_streamer u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    version_streamer #(.REPEAT_CYCLES(50)) u_dut_rep (
        .clk(clk), .rst_n(rst2_n), .req(req2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Header currently presented with out_ready=1: walk the frame, then expect done.
    task automatic frame_check(input string tag);
        for (int i = 0; i < LEN; i++) begin
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp_b[i]});
            chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
            step();
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic rdy_pat [0:3];
        int   k;
        int   cyc;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0; req = 1'b0; out_ready = 1'b1;
        rst2_n = 1'b0; req2 = 1'b0; out_ready2 = 1'b1;
        step(); step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // Single request, ready held high; header one cycle after the edge
        req = 1'b1; step(); req = 1'b0;
        chk("lat_header", {24'd0, out_data}, 32'hA5);
        frame_check("single");

        // Ready toggling 1,0,0,1: stalled bytes hold, none skipped or repeated
        req = 1'b1; step(); req = 1'b0;
        k = 0; cyc = 0;
        while (k < LEN && cyc < 100) begin
            out_ready = rdy_pat[cyc % 4];
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {24'd0, out_data}, {24'd0, exp_b[k]});
            if (out_ready) k++;
            step();
            cyc++;
        end
        chk("stall_count", k, LEN);
        chk("stall_done", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
        step();

        // Requests at bytes 3 and 5: one extra back-to-back frame, two dones
        req = 1'b1; step(); req = 1'b0;
        for (int i = 0; i < 2 * LEN; i++) begin
            req = (i == 3 || i == 5);
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_data", {24'd0, out_data}, {24'd0, exp_b[i % LEN]});
            chk("b2b_done", {31'd0, done}, {31'd0, i == LEN});
            step();
        end
        req = 1'b0;
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("b2b_quiet", {31'd0, done}, 32'd0);

        // Reset at byte 6: outputs drop immediately, no done, then a clean frame
        req = 1'b1; step(); req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_data", {24'd0, out_data}, {24'd0, exp_b[6]});
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        step();
        chk("arst_done_hold", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        req = 1'b1; step(); req = 1'b0;
        frame_check("after_rst");

        // Auto-send every 50 cycles: busy rises 50 cycles after reset release
        rst2_n = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            step();
            chk("rep_busy", {31'd0, busy2},
                {31'd0, (c >= 50) && (((c - 50) % 50) < LEN)});
            if (c >= 50 && ((c - 50) % 50) == 0)
                chk("rep_header", {24'd0, out_data2}, 32'hA5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
